// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Registered ALU execute stage (AND/OR/ADD/SUB) with a 2-entry
//            in-order result queue decoupling decode from a stalling consumer.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_control_op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam logic [3:0] C_OP_AND = 4'b0000;
  localparam logic [3:0] C_OP_OR  = 4'b0001;
  localparam logic [3:0] C_OP_ADD = 4'b0010;
  localparam logic [3:0] C_OP_SUB = 4'b0110;
  localparam logic [1:0] C_DEPTH  = 2'd2;

  // Queue storage: result, zero flag and illegal flag per entry
  logic [WIDTH-1:0] r_result  [2];
  logic             r_zero    [2];
  logic             r_illegal [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_illegal;
  logic             w_push;
  logic             w_pop;

  // Handshake status depends only on the registered occupancy count
  assign in_ready_o  = (r_count != C_DEPTH);
  assign out_valid_o = (r_count != 2'd0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;

  // ALU datapath; unsupported codes yield zero and raise the illegal flag
  always_comb begin
    w_alu_result  = '0;
    w_alu_illegal = 1'b0;
    case (alu_control_op_i)
      C_OP_AND: w_alu_result = operand_a_i & operand_b_i;
      C_OP_OR:  w_alu_result = operand_a_i | operand_b_i;
      C_OP_ADD: w_alu_result = operand_a_i + operand_b_i;
      C_OP_SUB: w_alu_result = operand_a_i - operand_b_i;
      default:  w_alu_illegal = 1'b1;
    endcase
  end

  // Write the accepted result into the slot at the write pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        r_result[i]  <= '0;
        r_zero[i]    <= 1'b0;
        r_illegal[i] <= 1'b0;
      end
    end else if (w_push && !flush_i) begin
      r_result[r_wptr]  <= w_alu_result;
      r_zero[r_wptr]    <= (w_alu_result == '0);
      r_illegal[r_wptr] <= w_alu_illegal;
    end
  end

  // Pointer and count bookkeeping; flush overrides any push/pop this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry presented to the consumer; forced to zero while empty
  always_comb begin
    result_o  = '0;
    zero_o    = 1'b0;
    illegal_o = 1'b0;
    if (out_valid_o) begin
      result_o  = r_result[r_rptr];
      zero_o    = r_zero[r_rptr];
      illegal_o = r_illegal[r_rptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Scoreboard bench for alu_exec_stage: driver pushes expected
//            results on accept, monitor compares every presented head entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             il;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [3:0]       alu_control_op_i = 4'h0;
  logic [WIDTH-1:0] operand_a_i = '0;
  logic [WIDTH-1:0] operand_b_i = '0;
  logic             flush_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             illegal_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .alu_control_op_i (alu_control_op_i),
    .operand_a_i      (operand_a_i),
    .operand_b_i      (operand_b_i),
    .flush_i          (flush_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .result_o         (result_o),
    .zero_o           (zero_o),
    .illegal_o        (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one request; the expected response enters the scoreboard when accepted
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] res, input logic z, input logic il);
    exp_t e;
    bit   taken = 1'b0;
    in_valid_i = 1'b1;
    alu_control_op_i = op;
    operand_a_i = a;
    operand_b_i = b;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        e.res = res; e.z = z; e.il = il;
        sb.push_back(e);
        taken = 1'b1;
      end
    end
    if (!taken) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: in_ready_o stayed 0 for op %h", op);
    end
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    operand_a_i = $urandom;
    operand_b_i = $urandom;
  endtask

  // Monitor: compare the presented head with the scoreboard front every cycle
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_output: result %h with empty scoreboard", result_o);
        end else begin
          check("head_result",  result_o,          sb[0].res);
          check("head_zero",    {31'b0, zero_o},    {31'b0, sb[0].z});
          check("head_illegal", {31'b0, illegal_o}, {31'b0, sb[0].il});
          if (out_ready_i) void'(sb.pop_front());
        end
      end else begin
        check("idle_outputs", {result_o[WIDTH-3:0], zero_o, illegal_o}, '0);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready",  {31'b0, in_ready_o},  32'd1);
    check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_result",    result_o,             32'd0);
    check("rst_flags",     {30'b0, zero_o, illegal_o}, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    mon_en = 1'b1;

    // Basic ADD, one-cycle latency, then empty
    out_ready_i = 1'b1;
    send(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    @(negedge clk_i);
    check("lat_valid", {31'b0, out_valid_o}, 32'd1);
    @(negedge clk_i);
    check("after_pop_valid", {31'b0, out_valid_o}, 32'd0);
    @(posedge clk_i); #1;

    // Back-to-back arithmetic/logic vectors at full throughput
    send(4'b0110, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
    send(4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    send(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0);
    send(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0);
    send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b1);
    repeat (2) @(posedge clk_i); #1;

    // Backpressure: fill both entries, third request held off
    out_ready_i = 1'b0;
    send(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    send(4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
    in_valid_i = 1'b1; alu_control_op_i = 4'b0010; operand_a_i = 32'd3; operand_b_i = 32'd3;
    repeat (2) begin
      @(negedge clk_i);
      check("full_in_ready", {31'b0, in_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    send(4'b0010, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i); #1;

    // Count 1 with simultaneous push and pop keeps one entry, order preserved
    out_ready_i = 1'b0;
    send(4'b0010, 32'd10, 32'd0, 32'd10, 1'b0, 1'b0);
    out_ready_i = 1'b1;
    send(4'b0001, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    out_ready_i = 1'b0;
    @(negedge clk_i);
    check("pushpop_valid", {31'b0, out_valid_o}, 32'd1);
    check("pushpop_ready", {31'b0, in_ready_o},  32'd1);
    check("pushpop_head",  result_o,             32'd3);
    @(posedge clk_i); #1;

    // Count 2 with simultaneous pop: push still refused
    send(4'b0010, 32'd20, 32'd1, 32'd21, 1'b0, 1'b0);
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; alu_control_op_i = 4'b0010; operand_a_i = 32'd7; operand_b_i = 32'd7;
    @(negedge clk_i);
    check("full_pop_ready", {31'b0, in_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("full_pop_left", result_o, 32'd21);
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    check("full_pop_drained", {31'b0, out_valid_o}, 32'd0);
    @(posedge clk_i); #1;

    // Flush with two entries and a request offered in the same cycle
    send(4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    send(4'b0010, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0);
    flush_i = 1'b1;
    in_valid_i = 1'b1; alu_control_op_i = 4'b0001; operand_a_i = 32'd8; operand_b_i = 32'd1;
    @(posedge clk_i);
    sb.delete();
    #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_valid", {31'b0, out_valid_o}, 32'd0);
    check("flush_ready", {31'b0, in_ready_o},  32'd1);
    @(posedge clk_i); #1;

    // Flush with one entry: the concurrent accepted-looking push is dropped
    send(4'b0010, 32'd6, 32'd6, 32'd12, 1'b0, 1'b0);
    flush_i = 1'b1; in_valid_i = 1'b1;
    @(posedge clk_i);
    sb.delete();
    #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush1_valid", {31'b0, out_valid_o}, 32'd0);
    @(posedge clk_i); #1;

    // Asynchronous reset mid-stream between edges
    send(4'b0010, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0);
    send(4'b1010, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
    #2;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    sb.delete();
    check("arst_valid",  {31'b0, out_valid_o}, 32'd0);
    check("arst_ready",  {31'b0, in_ready_o},  32'd1);
    check("arst_result", result_o,             32'd0);
    check("arst_flags",  {30'b0, zero_o, illegal_o}, 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i); #1;

    // Stage usable again after reset release
    out_ready_i = 1'b1;
    send(4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
